mux6_rr_arbiter: RTL

Round-robin arbiter that shares the CPU's 8-bit, six-source datapath multiplexer between six requesters. It drives the multiplexer's 3-bit select and a one-hot grant vector from registered state. It bounds each owner's tenure under contention and inserts one dead cycle between owners. When idle, it parks the select on an unused code so the multiplexer outputs 8'h00.

---
 rtl/mux6_rr_arbiter_if.sv | 33 +++
 rtl/mux6_rr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mux6_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mux6_rr_arbiter_if
// Purpose   : Request/select/grant bundle between the six requesters and
//             the round-robin arbiter of the 6-source datapath multiplexer.
// Revision  : 1.0 - initial release
// ============================================================================
interface mux6_rr_arbiter_if;
  logic [5:0] req;        // one request line per multiplexer input
  logic [2:0] sel;        // multiplexer select, 3'b111 parks on zero
  logic [5:0] grant;      // one-hot owner, all zero when nobody owns the bus
  logic       bus_valid;  // multiplexer output carries owner data
  logic       busy;       // arbiter is not idle

  // Requester side: drives requests, observes the arbitration result
  modport master (
    output req,
    input  sel,
    input  grant,
    input  bus_valid,
    input  busy
  );

  // Arbiter side
  modport slave (
    input  req,
    output sel,
    output grant,
    output bus_valid,
    output busy
  );
endinterface : mux6_rr_arbiter_if
`default_nettype wire

// File: rtl/mux6_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : mux6_rr_arbiter
// Purpose   : Round-robin arbiter sharing the 8-bit, six-source datapath
//             multiplexer. Bounded tenure under contention, one dead cycle
//             between owners, select parked on 3'b111 when idle.
// Revision  : 1.0 - initial release
// ============================================================================
module mux6_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4   // legal range 1..255
) (
  input  logic              clock,
  input  logic              resetn,
  mux6_rr_arbiter_if.slave  bus
);

  // Tenure counter needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int unsigned         c_CNT_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX  = c_CNT_W'(MAX_HOLD - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [2:0]          c_PARK     = 3'b111;
  // Last owner resets to 5 so the first search begins at index 0.
  localparam logic [2:0]          c_LAST_RST = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               r_state;
  logic [2:0]           r_owner;
  logic [2:0]           r_last;
  logic [c_CNT_W-1:0]   r_count;
  logic [2:0]           r_sel;
  logic [5:0]           r_grant;
  logic                 r_bus_valid;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic [2:0]           w_owner_nxt;
  logic [2:0]           w_last_nxt;
  logic [c_CNT_W-1:0]   w_count_nxt;
  logic [2:0]           w_sel_nxt;
  logic [5:0]           w_grant_nxt;
  logic                 w_bus_valid_nxt;
  logic                 w_busy_nxt;

  logic [2:0]           w_win;
  logic [5:0]           w_owner_oh;
  logic                 w_others;
  logic                 w_any;

  // Index that is 'step' positions after 'base', wrapping 5 -> 0.
  function automatic logic [2:0] f_idx(input logic [2:0] base, input logic [2:0] step);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 4'd6) begin
      sum = sum - 4'd6;
    end
    return sum[2:0];
  endfunction

  // Winner search from last+1; scanning backwards lets the earliest hit win.
  always_comb begin
    w_win = 3'd0;
    for (int k = 6; k >= 1; k--) begin
      if (bus.req[f_idx(r_last, 3'(k))]) begin
        w_win = f_idx(r_last, 3'(k));
      end
    end
  end

  assign w_any      = |bus.req;
  assign w_owner_oh = 6'b000001 << r_owner;
  assign w_others   = |(bus.req & ~w_owner_oh);

  // Next-state logic: arbitration, release, forced rotation and the gap cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    unique case (r_state)
      S_IDLE, S_GAP: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
          w_count_nxt = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = S_GAP;
        end else if ((r_count == c_CNT_MAX) && w_others) begin
          w_state_nxt = S_GAP;
        end else if (r_count != c_CNT_MAX) begin
          // A sole requester saturates here and keeps the bus.
          w_count_nxt = r_count + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode of the next state, so the registered outputs track the state.
  always_comb begin
    w_sel_nxt       = c_PARK;
    w_grant_nxt     = 6'b000000;
    w_bus_valid_nxt = 1'b0;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_GRANT) begin
      w_sel_nxt       = w_owner_nxt;
      w_grant_nxt     = 6'b000001 << w_owner_nxt;
      w_bus_valid_nxt = 1'b1;
    end
  end

  // State, pointer and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_owner     <= 3'd0;
      r_last      <= c_LAST_RST;
      r_count     <= '0;
      r_sel       <= c_PARK;
      r_grant     <= 6'b000000;
      r_bus_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_count     <= w_count_nxt;
      r_sel       <= w_sel_nxt;
      r_grant     <= w_grant_nxt;
      r_bus_valid <= w_bus_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.grant     = r_grant;
  assign bus.bus_valid = r_bus_valid;
  assign bus.busy      = r_busy;

endmodule : mux6_rr_arbiter
`default_nettype wire
